// File: rtl/traffic_pkg.sv
// Shared constants for the intersection phase scheduler: state codes,
// signal-head light codes and service direction.
package traffic_pkg;

    localparam logic [2:0] S_V_GREEN  = 3'd0;
    localparam logic [2:0] S_V_YELLOW = 3'd1;
    localparam logic [2:0] S_V_CLEAR  = 3'd2;
    localparam logic [2:0] S_H_GREEN  = 3'd3;
    localparam logic [2:0] S_H_YELLOW = 3'd4;
    localparam logic [2:0] S_H_CLEAR  = 3'd5;
    localparam logic [2:0] S_PED_WALK = 3'd6;

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

    localparam logic V = 1'b0;
    localparam logic H = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks; the first tick
// after reset lands on the CLK_DIV-th cycle.
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       r_cnt <= '0;
        else if (tick) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven intersection phase scheduler: gap-out/max-out greens, yellow,
// all-red clearance and an exclusive pedestrian walk phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v_sense,
    input  logic       h_sense,
    input  logic       ped_req,
    output logic [2:0] v_light,
    output logic [2:0] h_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    logic       w_tick;
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_elapsed;
    logic [7:0] w_new_el;
    logic       r_ped;
    logic       r_next_dir;
    logic       w_dir_nxt;
    logic       w_ge_min;
    logic       w_ge_max;
    logic [2:0] r_v_light;
    logic [2:0] r_h_light;
    logic       r_walk;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Transitions look at the elapsed count including the current tick.
    assign w_new_el = (r_elapsed == 8'hFF) ? 8'hFF : r_elapsed + 8'd1;
    assign w_ge_min = (int'(w_new_el) >= MIN_GREEN);
    assign w_ge_max = (int'(w_new_el) >= MAX_GREEN);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_next_dir;
        case (r_state)
            S_V_GREEN:
                if (w_tick && (h_sense || r_ped) && ((w_ge_min && !v_sense) || w_ge_max))
                    w_state_nxt = S_V_YELLOW;
            S_V_YELLOW:
                if (w_tick && int'(w_new_el) == YELLOW_T) w_state_nxt = S_V_CLEAR;
            S_V_CLEAR:
                if (w_tick && int'(w_new_el) == ALL_RED_T) begin
                    if (r_ped) begin
                        w_state_nxt = S_PED_WALK;
                        w_dir_nxt   = H;
                    end else begin
                        w_state_nxt = S_H_GREEN;
                    end
                end
            S_H_GREEN:
                if (w_tick && (v_sense || r_ped) && ((w_ge_min && !h_sense) || w_ge_max))
                    w_state_nxt = S_H_YELLOW;
            S_H_YELLOW:
                if (w_tick && int'(w_new_el) == YELLOW_T) w_state_nxt = S_H_CLEAR;
            S_H_CLEAR:
                if (w_tick && int'(w_new_el) == ALL_RED_T) begin
                    if (r_ped) begin
                        w_state_nxt = S_PED_WALK;
                        w_dir_nxt   = V;
                    end else begin
                        w_state_nxt = S_V_GREEN;
                    end
                end
            S_PED_WALK:
                if (w_tick && int'(w_new_el) == WALK_T)
                    w_state_nxt = (r_next_dir == H) ? S_H_GREEN : S_V_GREEN;
            default:
                w_state_nxt = S_V_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_V_GREEN;
            r_next_dir <= H;
            r_elapsed  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_dir <= w_dir_nxt;
            if (w_state_nxt != r_state) r_elapsed <= '0;
            else if (w_tick)            r_elapsed <= w_new_el;
        end
    end

    // Entering walk serves the request, including one arriving that same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_ped <= 1'b0;
        else if (w_state_nxt == S_PED_WALK && r_state != S_PED_WALK)
            r_ped <= 1'b0;
        else if (ped_req && r_state != S_PED_WALK)
            r_ped <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_light <= LIGHT_G;
            r_h_light <= LIGHT_R;
            r_walk    <= 1'b0;
        end else begin
            r_v_light <= LIGHT_R;
            r_h_light <= LIGHT_R;
            r_walk    <= 1'b0;
            case (r_state)
                S_V_GREEN:  r_v_light <= LIGHT_G;
                S_V_YELLOW: r_v_light <= LIGHT_Y;
                S_H_GREEN:  r_h_light <= LIGHT_G;
                S_H_YELLOW: r_h_light <= LIGHT_Y;
                S_PED_WALK: r_walk    <= 1'b1;
                default: ;
            endcase
        end
    end

    assign v_light     = r_v_light;
    assign h_light     = r_h_light;
    assign walk        = r_walk;
    assign ped_pending = r_ped;
    assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected phase changes with their cycle
// numbers; a monitor checks each change and the lights one cycle later.
module tb_traffic_phase_scheduler;

    localparam int P_VG = 0, P_VY = 1, P_VC = 2, P_HG = 3, P_HY = 4, P_HC = 5, P_PW = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_sense = 1'b0, h_sense = 1'b0, ped_req = 1'b0;
    logic [2:0] v_light, h_light, phase;
    logic       walk, ped_pending;

    typedef struct {
        int ph;
        int at;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    traffic_phase_scheduler #(
        .CLK_DIV(4), .MIN_GREEN(2), .MAX_GREEN(5),
        .YELLOW_T(2), .ALL_RED_T(1), .WALK_T(3)
    ) dut (
        .clk(clk), .rst(rst), .v_sense(v_sense), .h_sense(h_sense), .ped_req(ped_req),
        .v_light(v_light), .h_light(h_light), .walk(walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    // cyc = number of clock edges since the last edge that sampled rst high
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int exp_v(input int p);
        case (p)
            P_VG:    return 4;
            P_VY:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_h(input int p);
        case (p)
            P_HG:    return 4;
            P_HY:    return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int ph, input int at);
        exp_t e;
        e.ph = ph;
        e.at = at;
        q.push_back(e);
    endtask

    task automatic goto(input int n);
        int b;
        b = 0;
        while (cyc < n && b < 1000) begin
            @(negedge clk);
            b++;
        end
        chk("goto_cycle", cyc, n);
    endtask

    task automatic do_reset(input logic v, input logic h);
        rst = 1'b1;
        v_sense = v;
        h_sense = h;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    // Monitor: reset-induced changes (cyc == 0) are checked by the stimulus.
    initial begin
        logic [2:0] prev;
        logic [2:0] pph;
        bit         pend;
        exp_t       e;
        prev = 3'd0;
        pph  = 3'd0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("v_light_follow", v_light, exp_v(pph));
                chk("h_light_follow", h_light, exp_h(pph));
                chk("walk_follow", walk, (pph == 3'(P_PW)) ? 1 : 0);
                pend = 1'b0;
            end
            if (cyc != 0 && phase !== prev) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_phase: got %0d, expected %0d (cycle %0d)", phase, prev, cyc);
                end else begin
                    e = q.pop_front();
                    chk("phase", phase, e.ph);
                    chk("phase_cycle", cyc, e.at);
                end
                pend = 1'b1;
                pph  = phase;
            end
            prev = phase;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // 1: reset values, then idle rest in V_GREEN
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_phase", phase, P_VG);
        chk("rst_v_light", v_light, 4);
        chk("rst_h_light", h_light, 1);
        chk("rst_walk", walk, 0);
        chk("rst_ped", ped_pending, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_phase", phase, P_VG);
            chk("idle_v_light", v_light, 4);
            chk("idle_h_light", h_light, 1);
            chk("idle_walk", walk, 0);
        end

        // 2: horizontal demand, gap-out at tick 2
        push(P_VY, 8); push(P_VC, 16); push(P_HG, 20);
        do_reset(1'b0, 1'b1);
        goto(30);
        drain("t2_queue_empty");

        // 3: both detectors, max-out at tick 5
        push(P_VY, 20); push(P_VC, 28); push(P_HG, 32);
        do_reset(1'b1, 1'b1);
        goto(40);
        drain("t3_queue_empty");

        // 4: pedestrian pulse sampled at cycle 6
        push(P_VY, 8); push(P_VC, 16); push(P_PW, 20); push(P_HG, 32);
        do_reset(1'b0, 1'b0);
        goto(5); ped_req = 1'b1;
        goto(6); ped_req = 1'b0;
        chk("t4_ped_latched", ped_pending, 1);
        goto(21);
        chk("t4_ped_served", ped_pending, 0);
        chk("t4_walk_on", walk, 1);
        goto(60);
        drain("t4_queue_empty");
        chk("t4_rest_hg", phase, P_HG);

        // 5: requests on walk entry and during walk are not latched
        push(P_VY, 8); push(P_VC, 16); push(P_PW, 20); push(P_HG, 32);
        do_reset(1'b0, 1'b0);
        goto(5);  ped_req = 1'b1;
        goto(6);  ped_req = 1'b0;
        goto(19); ped_req = 1'b1;
        goto(20); ped_req = 1'b0;
        chk("t5_entry_absorb", ped_pending, 0);
        goto(24); ped_req = 1'b1;
        goto(25); ped_req = 1'b0;
        chk("t5_walk_drop", ped_pending, 0);
        goto(80);
        drain("t5_queue_empty");
        chk("t5_rest_hg", phase, P_HG);
        chk("t5_ped_idle", ped_pending, 0);

        // 6: reset in H_YELLOW with a pending request
        push(P_VY, 8); push(P_VC, 16); push(P_HG, 20); push(P_HY, 28);
        do_reset(1'b0, 1'b1);
        goto(20); h_sense = 1'b0; v_sense = 1'b1;
        goto(28); ped_req = 1'b1;
        goto(29); ped_req = 1'b0;
        chk("t6_ped_before_rst", ped_pending, 1);
        chk("t6_in_hy", phase, P_HY);
        drain("t6a_queue_empty");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_phase", phase, P_VG);
        chk("t6_rst_v_light", v_light, 4);
        chk("t6_rst_h_light", h_light, 1);
        chk("t6_rst_walk", walk, 0);
        chk("t6_rst_ped", ped_pending, 0);
        push(P_VY, 8); push(P_VC, 16); push(P_HG, 20);
        v_sense = 1'b0; h_sense = 1'b1;
        rst = 1'b0;
        goto(25);
        drain("t6b_queue_empty");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
